// File: rtl/bus_memory_responder.sv
// bus_memory_responder: single-port word RAM serving ibus/dbus one access at a time (dbus first), with wait states.
// Define ROM_PROTECT_EN to write-protect words [0, ROM_WORDS) against dbus stores.
module bus_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1,
  parameter int ROM_WORDS   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ibus_req,
  input  logic [31:0] ibus_addr,
  output logic [31:0] ibus_rdata,
  input  logic        dbus_req,
  input  logic        dbus_we,
  input  logic [31:0] dbus_addr,
  input  logic [3:0]  dbus_be,
  input  logic [31:0] dbus_wdata,
  output logic [31:0] dbus_rdata,
  output logic        stall,
  output logic        fault
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_sel_d;
  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_ibus_rdata;
  logic [31:0] r_dbus_rdata;
  logic        r_fault;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_idle;
  logic          w_any_req;
  logic          w_a_sel_d;
  logic [31:0]   w_a_addr;
  logic          w_a_we;
  logic [3:0]    w_a_be;
  logic [31:0]   w_a_wdata;
  logic [31:0]   w_idx_wide;
  logic [AW-1:0] w_ram_idx;
  logic          w_rom_err;
  logic          w_fault_now;
  logic [31:0]   w_old;
  logic [31:0]   w_merged;
  logic          w_do_access;
  logic          w_same;

  assign w_idle    = (r_state == S_IDLE);
  assign w_any_req = ibus_req | dbus_req;

  // In IDLE with zero wait states the access uses the live request, otherwise the latched one.
  assign w_a_sel_d = w_idle ? dbus_req : r_sel_d;
  assign w_a_addr  = w_idle ? (dbus_req ? dbus_addr : ibus_addr) : r_addr;
  assign w_a_we    = w_idle ? (dbus_req & dbus_we) : r_we;
  assign w_a_be    = w_idle ? dbus_be : r_be;
  assign w_a_wdata = w_idle ? dbus_wdata : r_wdata;

  assign w_idx_wide = {2'b00, w_a_addr[31:2]};
  assign w_ram_idx  = w_a_addr[AW+1:2];

`ifdef ROM_PROTECT_EN
  assign w_rom_err = w_a_we & (w_idx_wide < 32'(ROM_WORDS));
`else
  assign w_rom_err = 1'b0;
`endif

  assign w_fault_now = (|w_a_addr[1:0]) | (w_idx_wide >= 32'(DEPTH_WORDS)) | w_rom_err;
  assign w_old       = r_mem[w_ram_idx];

  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < 4; i++)
      if (w_a_be[i]) w_merged[8*i +: 8] = w_a_wdata[8*i +: 8];
  end

  assign w_do_access = (w_idle & w_any_req & (WAIT_STATES == 0)) |
                       ((r_state == S_WAIT) & (r_cnt == 4'd0));

  assign w_same = r_sel_d ?
                  (dbus_req & (dbus_addr == r_addr) & (dbus_we == r_we) &
                   (~r_we | ((dbus_be == r_be) & (dbus_wdata == r_wdata)))) :
                  (ibus_req & (ibus_addr == r_addr));

  assign stall      = (w_idle & w_any_req) | (r_state == S_WAIT);
  assign fault      = r_fault;
  assign ibus_rdata = r_ibus_rdata;
  assign dbus_rdata = r_dbus_rdata;

  always_ff @(posedge clk)
    if (rst && w_do_access && w_a_we && !w_fault_now)
      r_mem[w_ram_idx] <= w_merged;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_sel_d      <= 1'b0;
      r_addr       <= 32'd0;
      r_we         <= 1'b0;
      r_be         <= 4'd0;
      r_wdata      <= 32'd0;
      r_ibus_rdata <= 32'd0;
      r_dbus_rdata <= 32'd0;
      r_fault      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel_d <= w_a_sel_d;
            r_addr  <= w_a_addr;
            r_we    <= w_a_we;
            r_be    <= w_a_be;
            r_wdata <= w_a_wdata;
            r_cnt   <= CNT_INIT;
            r_state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_RESP: begin
          if (!w_same) begin
            r_state <= S_IDLE;
            r_fault <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_do_access) begin
        r_fault <= w_fault_now;
        if (w_a_sel_d) r_dbus_rdata <= w_fault_now ? 32'd0 : (w_a_we ? w_merged : w_old);
        else           r_ibus_rdata <= w_fault_now ? 32'd0 : w_old;
      end
    end
  end
endmodule

// File: tb/tb_bus_memory_responder.sv
// tb_bus_memory_responder: directed and random ibus/dbus accesses checked against a word-array model.
// Honours ROM_PROTECT_EN the same way the design does.
module tb_bus_memory_responder;
  localparam int DEPTH = 1024;
  localparam int WS    = 2;
  localparam int ROMW  = 256;
`ifdef ROM_PROTECT_EN
  localparam bit ROM = 1'b1;
`else
  localparam bit ROM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ibus_req = 1'b0;
  logic [31:0] ibus_addr = 32'd0;
  logic [31:0] ibus_rdata;
  logic        dbus_req = 1'b0;
  logic        dbus_we = 1'b0;
  logic [31:0] dbus_addr = 32'd0;
  logic [3:0]  dbus_be = 4'd0;
  logic [31:0] dbus_wdata = 32'd0;
  logic [31:0] dbus_rdata;
  logic        stall;
  logic        fault;

  always #5 clk = ~clk;

  bus_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .ROM_WORDS(ROMW)) dut (
    .clk(clk), .rst(rst),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_rdata(ibus_rdata),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .stall(stall), .fault(fault)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] exp_i = 32'd0, exp_d = 32'd0;
  bit          exp_i_k = 1'b1, exp_d_k = 1'b1;
  bit          exp_fault = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Updates the model for one access as the memory should see it.
  function automatic void model(input bit is_d, input bit we, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wdata);
    longint unsigned idx = longint'(addr >> 2);
    bit f = (addr[1:0] != 2'b00) || (idx >= DEPTH) || (ROM && is_d && we && idx < ROMW);
    exp_fault = f;
    if (f) begin
      if (is_d) begin exp_d = 32'd0; exp_d_k = 1'b1; end
      else      begin exp_i = 32'd0; exp_i_k = 1'b1; end
    end else if (is_d && we) begin
      if (m_known[idx] || be == 4'hF) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) m_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        m_known[idx] = 1'b1;
      end
      exp_d = m_mem[idx]; exp_d_k = m_known[idx];
    end else if (is_d) begin
      exp_d = m_mem[idx]; exp_d_k = m_known[idx];
    end else begin
      exp_i = m_mem[idx]; exp_i_k = m_known[idx];
    end
  endfunction

  task automatic wait_resp(input string tag);
    int n = 0;
    while (stall && n < 50) begin
      n++;
      @(negedge clk); #1;
    end
    chk({tag, "_lat"}, n, WS + 1);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, {31'd0, exp_fault});
    if (exp_i_k) chk({tag, "_irdata"}, ibus_rdata, exp_i);
    if (exp_d_k) chk({tag, "_drdata"}, dbus_rdata, exp_d);
  endtask

  task automatic access(input string tag, input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata, input int hold);
    @(negedge clk);
    if (is_d) begin
      dbus_req = 1'b1; dbus_we = we; dbus_addr = addr; dbus_be = be; dbus_wdata = wdata;
    end else begin
      ibus_req = 1'b1; ibus_addr = addr;
    end
    model(is_d, is_d && we, addr, be, wdata);
    #1;
    wait_resp(tag);
    check_outs(tag);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      check_outs({tag, "_hold"});
    end
    ibus_req = 1'b0; dbus_req = 1'b0;
    @(negedge clk); #1;
    chk({tag, "_idle_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_idle_fault"}, {31'd0, fault}, 32'd0);
  endtask

  task automatic rand_access(input int k);
    logic [31:0] a;
    bit d, w;
    case ($urandom_range(9))
      0:       a = ((32'd250 + $urandom_range(15)) << 2) | 32'($urandom_range(1, 3));
      1:       a = $urandom | 32'h8000_0000;
      2:       a = 32'(DEPTH * 4);
      3:       a = 32'((DEPTH - 1) * 4);
      default: a = (32'd250 + $urandom_range(15)) << 2;
    endcase
    d = ($urandom_range(2) != 0);
    w = d && ($urandom_range(1) != 0);
    access($sformatf("rnd%0d", k), d, w, a, 4'($urandom), $urandom, $urandom_range(3));
  endtask

  initial begin
    logic [31:0] saved;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 32'd0; m_known[i] = 1'b0; end
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_irdata", ibus_rdata, 32'd0);
    chk("rst_drdata", dbus_rdata, 32'd0);
    rst = 1'b1;

    // preload through full-word stores
    access("pre4", 1, 1, 32'h10, 4'hF, 32'h00A00093, 0);
    access("pre8", 1, 1, 32'h20, 4'hF, 32'h11223344, 0);
    access("pre16", 1, 1, 32'h40, 4'hF, 32'hCAFEF00D, 0);
    access("pre64", 1, 1, 32'h100, 4'hF, 32'h0BADBEEF, 0);
    access("prelast", 1, 1, 32'((DEPTH - 1) * 4), 4'hF, 32'h5A5A1234, 0);
    for (int i = 250; i < 270; i++)
      access("prew", 1, 1, 32'(i * 4), 4'hF, $urandom, 0);

    access("fetch", 0, 0, 32'h10, 4'h0, 32'd0, 3);
    access("st_b0", 1, 1, 32'h20, 4'b0001, 32'h0000_0055, 0);
    access("st_b1", 1, 1, 32'h20, 4'b0010, 32'h0000_AB00, 4);
    access("ld8", 1, 0, 32'h20, 4'h0, 32'd0, 0);

    // simultaneous requests: dbus first, ibus next
    @(negedge clk);
    ibus_req = 1'b1; ibus_addr = 32'h10;
    dbus_req = 1'b1; dbus_we = 1'b0; dbus_addr = 32'h40;
    model(1, 0, 32'h40, 4'h0, 32'd0);
    #1;
    wait_resp("both_d");
    check_outs("both_d");
    dbus_req = 1'b0;
    model(0, 0, 32'h10, 4'h0, 32'd0);
    @(negedge clk); #1;
    chk("both_i_pending", {31'd0, stall}, 32'd1);
    wait_resp("both_i");
    check_outs("both_i");
    ibus_req = 1'b0;
    @(negedge clk); #1;

    access("mis", 1, 0, 32'h22, 4'h0, 32'd0, 1);
    access("oor", 1, 0, 32'(DEPTH * 4), 4'h0, 32'd0, 0);
    access("oor_st", 1, 1, 32'(DEPTH * 4), 4'hF, 32'hFFFF_FFFF, 0);
    access("ld8b", 1, 0, 32'h20, 4'h0, 32'd0, 0);
    access("rom_st", 1, 1, 32'h100, 4'hF, 32'h1234_5678, 0);
    access("rom_ld", 1, 0, 32'h100, 4'h0, 32'd0, 0);
    access("ram_st", 1, 1, 32'h400, 4'hF, 32'h8765_4321, 0);
    access("ram_ld", 0, 0, 32'h400, 4'h0, 32'd0, 0);

    // reset during WAIT of a store: the word must keep its old value
    saved = m_mem[268];
    @(negedge clk);
    dbus_req = 1'b1; dbus_we = 1'b1; dbus_addr = 32'(268 * 4); dbus_be = 4'hF; dbus_wdata = ~saved;
    @(negedge clk); #1;
    chk("rstw_stall_wait", {31'd0, stall}, 32'd1);
    dbus_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("rstw_stall", {31'd0, stall}, 32'd0);
    chk("rstw_irdata", ibus_rdata, 32'd0);
    chk("rstw_drdata", dbus_rdata, 32'd0);
    chk("rstw_fault", {31'd0, fault}, 32'd0);
    exp_i = 32'd0; exp_d = 32'd0; exp_i_k = 1'b1; exp_d_k = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    access("rstw_ld", 1, 0, 32'(268 * 4), 4'h0, 32'd0, 0);

    for (int k = 0; k < 80; k++) rand_access(k);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
